// File: rtl/mem_pkg.sv
// Shared encodings and types for the MEM pipeline stage and its load aligner.
package mem_pkg;

    localparam logic [1:0] REG_SRC_ALU  = 2'b00;
    localparam logic [1:0] REG_SRC_LOAD = 2'b01;
    localparam logic [1:0] REG_SRC_PC   = 2'b10;
    localparam logic [1:0] REG_SRC_NONE = 2'b11;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_bundle_t;

    // Width 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
        case (width)
            WIDTH_BYTE: return 1'b0;
            WIDTH_HALF: return lo[0];
            default:    return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane select with sign/zero extension of the returned memory word.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (byte_off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = byte_off[1] ? word[31:16] : word[15:0];
        case (width)
            WIDTH_BYTE: data = {{24{sign_ext & lane_b[7]}}, lane_b};
            WIDTH_HALF: data = {{16{sign_ext & lane_h[15]}}, lane_h};
            default:    data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: load/store over a req/gnt/rvalid data port, producing the registered MEM/WB bundle.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into trap slots.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [XLEN-1:0] advance_pc_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] reg_2_data_i,
    input  logic [4:0]      reg_write_data_addr_i,
    input  logic [1:0]      mem_width_i,
    input  logic            mem_sign_extend_i,
    input  logic [1:0]      reg_src_i,
    input  logic            mem_write_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_be_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_addr_o,
    output logic [XLEN-1:0] wb_data_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
`endif
);

    function automatic logic [XLEN-1:0] steer_wdata(input logic [XLEN-1:0] d, input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return {4{d[7:0]}};
            WIDTH_HALF: return {2{d[15:0]}};
            default:    return d;
        endcase
    endfunction

    function automatic logic [3:0] steer_be(input logic [1:0] lo, input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 4'b0001 << lo;
            WIDTH_HALF: return 4'b0011 << {lo[1], 1'b0};
            default:    return 4'b1111;
        endcase
    endfunction

    mem_state_e      state, state_next;
    wb_bundle_t      wb, wb_next;
    logic            access, misaligned, start;
    logic [XLEN-1:0] addr_q, wdata_q, load_data;
    logic [3:0]      be_q;
    logic            we_q, sign_q;
    logic [1:0]      width_q, src_q;
    logic [4:0]      rd_q;

    assign access = valid_i & (mem_write_i | (reg_src_i == REG_SRC_LOAD));

`ifdef MEM_MISALIGN_TRAP_EN
    logic trap;
    assign misaligned = is_misaligned(mem_width_i, alu_result_i[1:0]);
    assign trap       = (state == ST_IDLE) & access & misaligned;
`else
    assign misaligned = 1'b0;
`endif

    mem_load_align u_align (
        .word     (dmem_rdata_i),
        .byte_off (addr_q[1:0]),
        .width    (width_q),
        .sign_ext (sign_q),
        .data     (load_data)
    );

    // Next state, stall and the write-back bundle that loads at the coming edge.
    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        start      = 1'b0;
        wb_next    = '0;
        case (state)
            ST_IDLE: begin
                if (access && misaligned) begin
                    wb_next.valid = 1'b1;
                    wb_next.addr  = reg_write_data_addr_i;
                    wb_next.data  = alu_result_i;
                end else if (access) begin
                    start      = 1'b1;
                    stall_o    = 1'b1;
                    state_next = ST_REQ;
                end else begin
                    wb_next.valid = valid_i;
                    wb_next.we    = valid_i & (reg_src_i != REG_SRC_NONE)
                                    & (reg_write_data_addr_i != 5'd0);
                    wb_next.addr  = reg_write_data_addr_i;
                    wb_next.data  = (reg_src_i == REG_SRC_PC) ? advance_pc_i : alu_result_i;
                end
            end
            ST_REQ: begin
                stall_o = 1'b1;
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        stall_o       = 1'b0;
                        wb_next.valid = 1'b1;
                        wb_next.addr  = rd_q;
                        wb_next.data  = addr_q;
                        state_next    = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_o = ~dmem_rvalid_i;
                if (dmem_rvalid_i) begin
                    wb_next.valid = 1'b1;
                    wb_next.we    = (src_q == REG_SRC_LOAD) & (rd_q != 5'd0);
                    wb_next.addr  = rd_q;
                    wb_next.data  = load_data;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch and MEM/WB boundary registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            wb      <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            width_q <= '0;
            sign_q  <= 1'b0;
            rd_q    <= '0;
            src_q   <= '0;
        end else begin
            state <= state_next;
            wb    <= wb_next;
            if (start) begin
                addr_q  <= alu_result_i;
                wdata_q <= steer_wdata(reg_2_data_i, mem_width_i);
                be_q    <= steer_be(alu_result_i[1:0], mem_width_i);
                we_q    <= mem_write_i;
                width_q <= mem_width_i;
                sign_q  <= mem_sign_extend_i;
                rd_q    <= reg_write_data_addr_i;
                src_q   <= reg_src_i;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            misalign_o <= trap;
            if (trap) misalign_addr_o <= alu_result_i;
        end
    end
`endif

    assign dmem_req_o   = (state == ST_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign wb_valid_o   = wb.valid;
    assign wb_we_o      = wb.we;
    assign wb_addr_o    = wb.addr;
    assign wb_data_o    = wb.data;

endmodule
